scatter_sched: RTL and testbench
================================

SCATTER_SCHED -- requirements
Module: scatter_sched

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 16, element width (FP16 bit pattern).
REQ-002 SHALL have parameter IN_SIZE, default 4, columns per row.
REQ-003 SHALL have parameter IN_PARALLELISM, default 1, rows per beat.
REQ-004 SHALL have parameter IN_DEPTH, default 8, beats per tile (>=1).
REQ-005 SHALL have ports, in this order:
- clk  input  1  clock; one clock domain.
- rst  input  1  reset; asynchronous, active-high.
- threshold  input  IN_WIDTH-1  magnitude threshold (FP16 without sign).
- data_in  input  IN_WIDTH x IN_SIZE*IN_PARALLELISM  row-major beat.
- data_in_valid  input  1.
- data_in_ready  output  1.
- data_out_large  output  IN_WIDTH x IN_SIZE*IN_PARALLELISM  outlier columns, others zero.
- data_out_large_valid  output  1.
- data_out_large_ready  input  1.
- data_out_small  output  IN_WIDTH x IN_SIZE*IN_PARALLELISM  normal columns, others zero.
- data_out_small_valid  output  1.
- data_out_small_ready  input  1.
- col_mask  output  IN_SIZE  bit j=1: column j is large for the current tile.
- large_count  output  $clog2(IN_SIZE+1)  popcount of col_mask.
- tile_last  output  1  output slots hold the last beat of a tile.

Function
REQ-006 SHALL use states IDLE (await first beat of a tile) and STREAM (beats 2..IN_DEPTH).
REQ-007 In IDLE, on input accept, SHALL set col_mask bit j=1 iff any row of that beat has element j with bits [IN_WIDTH-2:0] > threshold (unsigned compare).
REQ-008 SHALL latch threshold only at first-beat accept; threshold changes mid-tile SHALL have no effect.
REQ-009 SHALL hold col_mask and large_count constant from first-beat accept until the next tile's first-beat accept.
REQ-010 Input accept SHALL mean data_in_valid && data_in_ready.
REQ-011 data_in_ready SHALL equal !rst && (!large_valid || large_ready) && (!small_valid || small_ready).
REQ-012 On accept, SHALL register both outputs on the next edge (latency 1):
- element (r,j) goes to large if col_mask[j], else to small;
- the other output gets 0 at that position.
REQ-013 On accept, SHALL assert both data_out_large_valid and data_out_small_valid.
REQ-014 Each output valid SHALL clear independently on its own handshake unless a new accept occurs in the same cycle.
REQ-015 Output data SHALL be stable while its valid is high and ready is low.
REQ-016 SHALL sustain one beat per cycle when both readies are held high.
REQ-017 A beat counter SHALL count accepts 0..IN_DEPTH-1 and wrap to 0 on the accept at IN_DEPTH-1, returning to IDLE.
REQ-018 With IN_DEPTH=1, every beat SHALL be a first and last beat; the FSM SHALL stay in IDLE.
REQ-019 tile_last SHALL be registered with the beat and be 1 iff the beat was accepted at count IN_DEPTH-1.
REQ-020 IDLE->STREAM SHALL occur on first-beat accept when IN_DEPTH>1.
REQ-021 STREAM->IDLE SHALL occur on accept at count IN_DEPTH-1.
REQ-022 Otherwise the state SHALL hold.

Reset
REQ-023 On rst, all of the following SHALL be 0 immediately:
- data_out_large_valid, data_out_small_valid, tile_last;
- data_out_large, data_out_small;
- col_mask, large_count;
- counter, latched threshold.
REQ-024 On rst, the state SHALL be IDLE.
REQ-025 Reset mid-tile SHALL discard the partial tile; the first beat after reset SHALL start a new tile.

Structure
REQ-026 Package scatter_pkg SHALL hold the state enum and the FP16 magnitude-mask constant.
REQ-027 Sub-module scatter_col_detect SHALL be purely combinational and hold the per-column threshold compare and popcount.
REQ-028 The FSM, counter, fork registers and zero-fill routing SHALL be in scatter_sched.

Verification
Common setup: IN_SIZE=4, IN_PARALLELISM=1, IN_DEPTH=3, threshold=0x4000; beats listed as element 0..3.
REQ-029 Basic split:
- stimulus: beat [0x3C00,0x4400,0xC400,0x3800], both readies high;
- response: col_mask=0b0110, large_count=2 at next cycle; large=[0,0x4400,0xC400,0], small=[0x3C00,0,0,0x3800].
REQ-030 Mask hold:
- stimulus: beats 2 and 3 = [0x5000,0x3C00,0x3C00,0x5000];
- response: mask stays 0b0110; large=[0,0x3C00,0x3C00,0]; tile_last=1 on beat 3 only; state IDLE after.
REQ-031 Independent backpressure:
- stimulus: small_ready low 4 cycles, large_ready high;
- response: large handshakes once then valid drops; small stays valid with stable data; data_in_ready=0 until the small handshake.
REQ-032 Full throughput:
- stimulus: 6 back-to-back beats, both readies high;
- response: 6 outputs on 6 consecutive cycles; tile_last on outputs 3 and 6; mask recomputed at beat 4.
REQ-033 Reset mid-tile:
- stimulus: assert rst after beat 2;
- response: all valids 0 and col_mask 0 at once; the next beat is treated as a first beat.
REQ-034 Threshold change:
- stimulus: threshold=0x3000 during beat 2;
- response: mask unchanged; the new value applies at the next tile.

Source files
------------

// File: rtl/scatter_pkg.sv
// Shared types and constants for the column-scatter scheduler.
package scatter_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  // Strips the FP16 sign bit so outliers of either sign compare by magnitude.
  localparam logic [15:0] FP16_MAG_MASK = 16'h7FFF;

endpackage

// File: rtl/scatter_col_detect.sv
// Combinational outlier-column detection: per-column magnitude compare across
// all rows of a beat, plus popcount of the resulting column mask.
import scatter_pkg::*;

module scatter_col_detect #(
  parameter int IN_WIDTH       = 16,
  parameter int IN_SIZE        = 4,
  parameter int IN_PARALLELISM = 1,
  parameter int LC_W           = $clog2(IN_SIZE + 1)
) (
  input  logic [IN_WIDTH-2:0]                              threshold,
  input  logic [IN_SIZE*IN_PARALLELISM-1:0][IN_WIDTH-1:0]  beat,
  output logic [IN_SIZE-1:0]                               mask,
  output logic [LC_W-1:0]                                  count
);

  localparam logic [IN_WIDTH-1:0] MAG_MASK = (IN_WIDTH == 16) ?
    IN_WIDTH'(FP16_MAG_MASK) : {1'b0, {(IN_WIDTH-1){1'b1}}};

  // NOTE: every output gets a default at the top of always_comb so no path
  // leaves it unassigned; that is what keeps this block free of latches.
  always_comb begin
    mask  = '0;
    count = '0;
    for (int r = 0; r < IN_PARALLELISM; r++) begin
      for (int j = 0; j < IN_SIZE; j++) begin
        if ((beat[r*IN_SIZE+j] & MAG_MASK) > {1'b0, threshold}) begin
          mask[j] = 1'b1;
        end
      end
    end
    for (int j = 0; j < IN_SIZE; j++) begin
      count = count + LC_W'(mask[j]);
    end
  end

endmodule

// File: rtl/scatter_sched.sv
// Tile scheduler: decides outlier columns on the first beat of each tile and
// forks every beat into zero-filled large/small streams with independent valids.
import scatter_pkg::*;

module scatter_sched #(
  parameter int IN_WIDTH       = 16,
  parameter int IN_SIZE        = 4,
  parameter int IN_PARALLELISM = 1,
  parameter int IN_DEPTH       = 8
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic [IN_WIDTH-2:0]                              threshold,
  input  logic [IN_SIZE*IN_PARALLELISM-1:0][IN_WIDTH-1:0]  data_in,
  input  logic                                             data_in_valid,
  output logic                                             data_in_ready,
  output logic [IN_SIZE*IN_PARALLELISM-1:0][IN_WIDTH-1:0]  data_out_large,
  output logic                                             data_out_large_valid,
  input  logic                                             data_out_large_ready,
  output logic [IN_SIZE*IN_PARALLELISM-1:0][IN_WIDTH-1:0]  data_out_small,
  output logic                                             data_out_small_valid,
  input  logic                                             data_out_small_ready,
  output logic [IN_SIZE-1:0]                               col_mask,
  output logic [$clog2(IN_SIZE+1)-1:0]                     large_count,
  output logic                                             tile_last
);

  localparam int N     = IN_SIZE * IN_PARALLELISM;
  localparam int CNT_W = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam int LC_W  = $clog2(IN_SIZE + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_DEPTH - 1);

  state_e                          state_q, state_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [IN_WIDTH-2:0]             thr_q, thr_d;
  logic [IN_SIZE-1:0]              col_mask_q, col_mask_d;
  logic [LC_W-1:0]                 large_count_q, large_count_d;
  logic [N-1:0][IN_WIDTH-1:0]      large_q, large_d, small_q, small_d;
  logic                            large_valid_q, large_valid_d;
  logic                            small_valid_q, small_valid_d;
  logic                            tile_last_q, tile_last_d;

  logic                            accept, first_beat, last_beat;
  logic [IN_WIDTH-2:0]             det_thr;
  logic [IN_SIZE-1:0]              det_mask, mask_eff;
  logic [LC_W-1:0]                 det_count;

  assign data_in_ready = !rst && (!large_valid_q || data_out_large_ready)
                              && (!small_valid_q || data_out_small_ready);
  assign accept     = data_in_valid && data_in_ready;
  assign first_beat = (state_q == IDLE);
  assign last_beat  = (cnt_q == LAST_CNT);

  // Detection only matters on a first beat, where the live threshold is used.
  assign det_thr  = first_beat ? threshold : thr_q;
  assign mask_eff = first_beat ? det_mask : col_mask_q;

  scatter_col_detect #(
    .IN_WIDTH       (IN_WIDTH),
    .IN_SIZE        (IN_SIZE),
    .IN_PARALLELISM (IN_PARALLELISM),
    .LC_W           (LC_W)
  ) u_detect (
    .threshold (det_thr),
    .beat      (data_in),
    .mask      (det_mask),
    .count     (det_count)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    thr_d         = thr_q;
    col_mask_d    = col_mask_q;
    large_count_d = large_count_q;
    large_d       = large_q;
    small_d       = small_q;
    large_valid_d = large_valid_q;
    small_valid_d = small_valid_q;
    tile_last_d   = tile_last_q;

    if (accept) begin
      if (first_beat) begin
        thr_d         = threshold;
        col_mask_d    = det_mask;
        large_count_d = det_count;
      end
      for (int k = 0; k < N; k++) begin
        if (mask_eff[k % IN_SIZE]) begin
          large_d[k] = data_in[k];
          small_d[k] = '0;
        end else begin
          large_d[k] = '0;
          small_d[k] = data_in[k];
        end
      end
      large_valid_d = 1'b1;
      small_valid_d = 1'b1;
      tile_last_d   = last_beat;
      if (last_beat) begin
        cnt_d   = '0;
        state_d = IDLE;
      end else begin
        cnt_d   = cnt_q + 1'b1;
        state_d = STREAM;
      end
    end else begin
      if (large_valid_q && data_out_large_ready) large_valid_d = 1'b0;
      if (small_valid_q && data_out_small_ready) small_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      thr_q         <= '0;
      col_mask_q    <= '0;
      large_count_q <= '0;
      large_q       <= '0;
      small_q       <= '0;
      large_valid_q <= 1'b0;
      small_valid_q <= 1'b0;
      tile_last_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      thr_q         <= thr_d;
      col_mask_q    <= col_mask_d;
      large_count_q <= large_count_d;
      large_q       <= large_d;
      small_q       <= small_d;
      large_valid_q <= large_valid_d;
      small_valid_q <= small_valid_d;
      tile_last_q   <= tile_last_d;
    end
  end

  assign data_out_large       = large_q;
  assign data_out_small       = small_q;
  assign data_out_large_valid = large_valid_q;
  assign data_out_small_valid = small_valid_q;
  assign col_mask             = col_mask_q;
  assign large_count          = large_count_q;
  assign tile_last            = tile_last_q;

endmodule

// File: tb/tb_scatter_sched.sv
// Directed bench for scatter_sched with IN_SIZE=4, IN_PARALLELISM=1, IN_DEPTH=3.
module tb_scatter_sched;

  logic             clk = 1'b0;
  logic             rst;
  logic [14:0]      threshold;
  logic [3:0][15:0] data_in;
  logic             data_in_valid;
  logic             data_in_ready;
  logic [3:0][15:0] data_out_large;
  logic             data_out_large_valid;
  logic             data_out_large_ready;
  logic [3:0][15:0] data_out_small;
  logic             data_out_small_valid;
  logic             data_out_small_ready;
  logic [3:0]       col_mask;
  logic [2:0]       large_count;
  logic             tile_last;

  int n_cmp = 0;
  int n_err = 0;

  scatter_sched #(
    .IN_WIDTH       (16),
    .IN_SIZE        (4),
    .IN_PARALLELISM (1),
    .IN_DEPTH       (3)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .threshold            (threshold),
    .data_in              (data_in),
    .data_in_valid        (data_in_valid),
    .data_in_ready        (data_in_ready),
    .data_out_large       (data_out_large),
    .data_out_large_valid (data_out_large_valid),
    .data_out_large_ready (data_out_large_ready),
    .data_out_small       (data_out_small),
    .data_out_small_valid (data_out_small_valid),
    .data_out_small_ready (data_out_small_ready),
    .col_mask             (col_mask),
    .large_count          (large_count),
    .tile_last            (tile_last)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] v4(input logic [15:0] e0, input logic [15:0] e1,
                                     input logic [15:0] e2, input logic [15:0] e3);
    return {e3, e2, e1, e0};
  endfunction

  task automatic check_out(input string tag, input logic [63:0] exp_large,
                           input logic [63:0] exp_small, input logic [3:0] exp_mask,
                           input logic [2:0] exp_cnt, input logic exp_last);
    check({tag, ".large"},   data_out_large, exp_large);
    check({tag, ".small"},   data_out_small, exp_small);
    check({tag, ".lvalid"},  data_out_large_valid, 1);
    check({tag, ".svalid"},  data_out_small_valid, 1);
    check({tag, ".mask"},    col_mask, exp_mask);
    check({tag, ".lcount"},  large_count, exp_cnt);
    check({tag, ".last"},    tile_last, exp_last);
  endtask

  // Presents one beat for a single cycle; returns at the negedge after the accept edge.
  task automatic send_one(input logic [63:0] d);
    @(negedge clk);
    data_in       = d;
    data_in_valid = 1'b1;
    @(negedge clk);
    data_in_valid = 1'b0;
  endtask

  logic [63:0] tp_beats [6];
  logic [63:0] tp_large [6];
  logic [63:0] tp_small [6];
  logic [3:0]  tp_mask  [6];

  initial begin
    rst                  = 1'b1;
    threshold            = 15'h4000;
    data_in              = '0;
    data_in_valid        = 1'b0;
    data_out_large_ready = 1'b1;
    data_out_small_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst.lvalid", data_out_large_valid, 0);
    check("rst.svalid", data_out_small_valid, 0);
    check("rst.mask",   col_mask, 0);
    check("rst.lcount", large_count, 0);
    check("rst.last",   tile_last, 0);
    check("rst.large",  data_out_large, 0);
    check("rst.small",  data_out_small, 0);
    check("rst.ready",  data_in_ready, 0);
    rst = 1'b0;
    #1 check("post_rst.ready", data_in_ready, 1);

    // Basic split, then mask hold with a mid-tile threshold change
    send_one(v4(16'h3C00, 16'h4400, 16'hC400, 16'h3800));
    check_out("t1b1", v4(0, 16'h4400, 16'hC400, 0), v4(16'h3C00, 0, 0, 16'h3800), 4'b0110, 3'd2, 1'b0);
    threshold = 15'h3000;
    send_one(v4(16'h5000, 16'h3C00, 16'h3C00, 16'h5000));
    check_out("t1b2", v4(0, 16'h3C00, 16'h3C00, 0), v4(16'h5000, 0, 0, 16'h5000), 4'b0110, 3'd2, 1'b0);
    send_one(v4(16'h5000, 16'h3C00, 16'h3C00, 16'h5000));
    check_out("t1b3", v4(0, 16'h3C00, 16'h3C00, 0), v4(16'h5000, 0, 0, 16'h5000), 4'b0110, 3'd2, 1'b1);

    // New tile picks up threshold 0x3000
    send_one(v4(16'h3C00, 16'h2000, 16'h3400, 16'hB800));
    check_out("t2b1", v4(16'h3C00, 0, 16'h3400, 16'hB800), v4(0, 16'h2000, 0, 0), 4'b1101, 3'd3, 1'b0);

    // Independent backpressure on the small stream
    @(negedge clk);
    data_out_small_ready = 1'b0;
    data_in       = v4(16'h4000, 16'h4001, 16'h0000, 16'h8001);
    data_in_valid = 1'b1;
    @(negedge clk);
    check_out("bp.accept", v4(16'h4000, 0, 0, 16'h8001), v4(0, 16'h4001, 0, 0), 4'b1101, 3'd3, 1'b0);
    check("bp.ready0", data_in_ready, 0);
    data_in = v4(16'h1111, 16'h5555, 16'h0000, 16'hFFFF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp.lvalid_drop", data_out_large_valid, 0);
      check("bp.svalid_hold", data_out_small_valid, 1);
      check("bp.small_stable", data_out_small, v4(0, 16'h4001, 0, 0));
      check("bp.ready_low", data_in_ready, 0);
    end
    data_out_small_ready = 1'b1;
    #1 check("bp.ready_release", data_in_ready, 1);
    @(negedge clk);
    check_out("t2b3", v4(16'h1111, 0, 0, 16'hFFFF), v4(0, 16'h5555, 0, 0), 4'b1101, 3'd3, 1'b1);
    data_in_valid = 1'b0;

    // Full throughput: six back-to-back beats spanning two tiles
    threshold   = 15'h4000;
    tp_beats[0] = v4(16'h4400, 0, 0, 0);
    tp_beats[1] = v4(16'h1234, 16'h4400, 0, 0);
    tp_beats[2] = v4(0, 0, 16'h4400, 0);
    tp_beats[3] = v4(0, 0, 0, 16'h4800);
    tp_beats[4] = v4(16'h4401, 0, 0, 0);
    tp_beats[5] = v4(0, 0, 0, 0);
    tp_large[0] = v4(16'h4400, 0, 0, 0);   tp_small[0] = 0;                       tp_mask[0] = 4'b0001;
    tp_large[1] = v4(16'h1234, 0, 0, 0);   tp_small[1] = v4(0, 16'h4400, 0, 0);  tp_mask[1] = 4'b0001;
    tp_large[2] = 0;                       tp_small[2] = v4(0, 0, 16'h4400, 0); tp_mask[2] = 4'b0001;
    tp_large[3] = v4(0, 0, 0, 16'h4800);   tp_small[3] = 0;                       tp_mask[3] = 4'b1000;
    tp_large[4] = 0;                       tp_small[4] = v4(16'h4401, 0, 0, 0);  tp_mask[4] = 4'b1000;
    tp_large[5] = 0;                       tp_small[5] = 0;                       tp_mask[5] = 4'b1000;
    @(negedge clk);
    data_in       = tp_beats[0];
    data_in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_out($sformatf("tp%0d", i), tp_large[i], tp_small[i], tp_mask[i], 3'd1, (i == 2) || (i == 5));
      check($sformatf("tp%0d.ready", i), data_in_ready, 1);
      if (i < 5) data_in = tp_beats[i+1];
      else       data_in_valid = 1'b0;
    end

    // Reset mid-tile discards the partial tile
    send_one(v4(16'h4400, 0, 0, 0));
    check("rst_mid.b1.mask", col_mask, 4'b0001);
    send_one(v4(16'h4400, 16'h4400, 0, 0));
    check("rst_mid.b2.mask", col_mask, 4'b0001);
    check("rst_mid.b2.last", tile_last, 0);
    rst = 1'b1;
    #1;
    check("rst_mid.lvalid", data_out_large_valid, 0);
    check("rst_mid.svalid", data_out_small_valid, 0);
    check("rst_mid.mask",   col_mask, 0);
    check("rst_mid.lcount", large_count, 0);
    check("rst_mid.large",  data_out_large, 0);
    check("rst_mid.small",  data_out_small, 0);
    check("rst_mid.ready",  data_in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    send_one(v4(0, 0, 0, 16'h4400));
    check_out("after_rst.b1", v4(0, 0, 0, 16'h4400), 0, 4'b1000, 3'd1, 1'b0);
    send_one(v4(16'h4400, 0, 0, 16'h0100));
    check_out("after_rst.b2", v4(0, 0, 0, 16'h0100), v4(16'h4400, 0, 0, 0), 4'b1000, 3'd1, 1'b0);
    send_one(v4(0, 16'h7C00, 0, 16'hFC00));
    check_out("after_rst.b3", v4(0, 0, 0, 16'hFC00), v4(0, 16'h7C00, 0, 0), 4'b1000, 3'd1, 1'b1);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
